// File: rtl/systolic_feeder_if.sv
// Load/edge/completion signal bundle between the systolic feeder, its operand
// source, the N x N MAC array edges and the downstream result reader.
interface systolic_feeder_if #(
  parameter int DATA_SIZE = 8,
  parameter int N         = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N*DATA_SIZE-1:0] in_a_col;
  logic [N*DATA_SIZE-1:0] in_b_row;
  logic                   pe_clear;
  logic                   edge_valid;
  logic [N*DATA_SIZE-1:0] a_edge;
  logic [N*DATA_SIZE-1:0] b_edge;
  logic                   done;
  logic                   done_ack;

  // Feeder side.
  modport master (
    input  in_valid, in_a_col, in_b_row, done_ack,
    output in_ready, pe_clear, edge_valid, a_edge, b_edge, done
  );

  // Source / array / reader side.
  modport slave (
    output in_valid, in_a_col, in_b_row, done_ack,
    input  in_ready, pe_clear, edge_valid, a_edge, b_edge, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers an N x N tile of A (columns) and B (rows) and streams it into the
// systolic array edges with diagonal skew. SYSTOLIC_FEEDER_DBUF_EN enables ping-pong buffering.
module systolic_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int N         = 4
) (
  input  logic              clk,
  input  logic              reset,
  systolic_feeder_if.master bus
);
  localparam int KW     = $clog2(N);
  localparam int TW     = $clog2(3*N);
  localparam int T_LAST = 3*N - 3;
  localparam int W      = N*DATA_SIZE;

  typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_STREAM, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         t_q, t_d;
  logic [KW-1:0]         beat_q, beat_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [W-1:0]          a_edge_q, a_edge_d;
  logic [W-1:0]          b_edge_q, b_edge_d;
  logic                  in_ready_s;
  logic                  wr_fire_s;
  logic                  wr_last_s;
  logic [DATA_SIZE-1:0]  a_mem_q [2][N][N];
  logic [DATA_SIZE-1:0]  b_mem_q [2][N][N];

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  logic [1:0]            full_q, full_d;
  logic                  release_s;

  assign in_ready_s = ~full_q[wr_q];
  assign release_s  = (state_q == S_DONE) && bus.done_ack;
`else
  assign in_ready_s = (state_q == S_LOAD);
`endif

  assign wr_fire_s = bus.in_valid && in_ready_s;
  assign wr_last_s = wr_fire_s && (beat_q == KW'(N-1));

  // Tile buffer write: beat k fills column k of A and row k of B.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      for (int i = 0; i < N; i++) begin
        a_mem_q[wr_q][i][beat_q] <= bus.in_a_col[i*DATA_SIZE +: DATA_SIZE];
        b_mem_q[wr_q][beat_q][i] <= bus.in_b_row[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Beat counter and write-bank bookkeeping.
  always_comb begin
    beat_d = beat_q;
    wr_d   = wr_q;
    if (wr_fire_s) begin
      beat_d = wr_last_s ? '0 : beat_q + 1'b1;
    end else begin
      beat_d = beat_q;
    end
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    full_d = full_q;
    if (release_s) begin
      full_d[rd_q] = 1'b0;
    end else begin
      full_d[rd_q] = full_q[rd_q];
    end
    // The bank being released is never the one being completed.
    if (wr_last_s) begin
      full_d[wr_q] = 1'b1;
      wr_d         = ~wr_q;
    end else begin
      wr_d         = wr_q;
    end
`endif
  end

  // FSM next state, stream counter and read-bank selection.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    rd_d    = rd_q;
    case (state_q)
      S_LOAD: begin
        if (wr_last_s) state_d = S_CLEAR;
        else           state_d = S_LOAD;
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        t_d     = '0;
      end
      S_STREAM: begin
        if (t_q == TW'(T_LAST)) state_d = S_DONE;
        else                    t_d     = t_q + 1'b1;
      end
      S_DONE: begin
        if (bus.done_ack) begin
`ifdef SYSTOLIC_FEEDER_DBUF_EN
          rd_d = ~rd_q;
          if (full_q[~rd_q] || (wr_last_s && (wr_q != rd_q))) state_d = S_CLEAR;
          else                                                 state_d = S_LOAD;
`else
          state_d = S_LOAD;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_LOAD;
        t_d     = '0;
      end
    endcase
  end

  // Skewed edge operands for the upcoming stream cycle; lanes outside the diagonal are zero.
  always_comb begin
    a_edge_d = '0;
    b_edge_d = '0;
    if (state_d == S_STREAM) begin
      for (int x = 0; x < N; x++) begin
        if ((int'(t_d) >= x) && ((int'(t_d) - x) < N)) begin
          a_edge_d[x*DATA_SIZE +: DATA_SIZE] = a_mem_q[rd_q][x][KW'(int'(t_d) - x)];
          b_edge_d[x*DATA_SIZE +: DATA_SIZE] = b_mem_q[rd_q][KW'(int'(t_d) - x)][x];
        end else begin
          a_edge_d[x*DATA_SIZE +: DATA_SIZE] = '0;
          b_edge_d[x*DATA_SIZE +: DATA_SIZE] = '0;
        end
      end
    end else begin
      a_edge_d = '0;
      b_edge_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_LOAD;
      t_q      <= '0;
      beat_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      a_edge_q <= '0;
      b_edge_q <= '0;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
      full_q   <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      beat_q   <= beat_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      a_edge_q <= a_edge_d;
      b_edge_q <= b_edge_d;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
      full_q   <= full_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.pe_clear   = (state_q == S_CLEAR);
  assign bus.edge_valid = (state_q == S_STREAM);
  assign bus.done       = (state_q == S_DONE);
  assign bus.a_edge     = a_edge_q;
  assign bus.b_edge     = b_edge_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: random tiles checked against a
// skew-formula reference model; honours SYSTOLIC_FEEDER_DBUF_EN.
module tb_systolic_feeder;
  localparam int DS = 8;
  localparam int N  = 4;
  localparam int W  = N*DS;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [DS-1:0] ld_a [N][N];
  logic [DS-1:0] ld_b [N][N];
  logic [DS-1:0] st_a [N][N];
  logic [DS-1:0] st_b [N][N];

  systolic_feeder_if #(.DATA_SIZE(DS), .N(N)) bus ();

  systolic_feeder #(.DATA_SIZE(DS), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lane i of a_edge at time t is A[i][t-i], lane j of b_edge is B[t-j][j].
  function automatic logic [W-1:0] exp_a_edge(input int t);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*DS +: DS] = st_a[i][t-i];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_b_edge(input int t);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*DS +: DS] = st_b[t-j][j];
    return r;
  endfunction

  task automatic rand_tile();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ld_a[r][c] = DS'($urandom_range(0, 255));
        ld_b[r][c] = DS'($urandom_range(0, 255));
      end
  endtask

  task automatic commit_tile();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        st_a[r][c] = ld_a[r][c];
        st_b[r][c] = ld_b[r][c];
      end
  endtask

  task automatic load_tile(input bit gaps);
    bit accepted;
    int guard;
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          bus.in_valid = 1'b0;
          bus.in_a_col = W'($urandom);
          bus.in_b_row = W'($urandom);
          tick();
        end
      end
      for (int x = 0; x < N; x++) begin
        bus.in_a_col[x*DS +: DS] = ld_a[x][k];
        bus.in_b_row[x*DS +: DS] = ld_b[k][x];
      end
      bus.in_valid = 1'b1;
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 200) begin
        accepted = (bus.in_ready === 1'b1);
        tick();
        guard++;
      end
      if (!accepted) begin
        total_cnt++;
        $display("FAIL load_timeout: beat %0d not accepted, in_ready=%b required 1", k, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Starts in the CLEAR cycle, ends in the first DONE cycle.
  task automatic check_tile_stream(input string tag);
    total_cnt++;
    if (bus.pe_clear !== 1'b1 || bus.edge_valid !== 1'b0)
      $display("FAIL %s_clear: pe_clear=%b edge_valid=%b required 1/0", tag, bus.pe_clear, bus.edge_valid);
    else pass_cnt++;
`ifndef SYSTOLIC_FEEDER_DBUF_EN
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL %s_ready_clear: in_ready=%b required 0", tag, bus.in_ready);
    else pass_cnt++;
`endif
    tick();
    for (int t = 0; t <= 3*N-3; t++) begin
      total_cnt++;
      if (bus.edge_valid !== 1'b1 || bus.pe_clear !== 1'b0 || bus.done !== 1'b0)
        $display("FAIL %s_ctl_t%0d: valid/clear/done=%b%b%b required 100", tag, t, bus.edge_valid, bus.pe_clear, bus.done);
      else pass_cnt++;
      total_cnt++;
      if (bus.a_edge !== exp_a_edge(t))
        $display("FAIL %s_a_edge_t%0d: got %h required %h", tag, t, bus.a_edge, exp_a_edge(t));
      else pass_cnt++;
      total_cnt++;
      if (bus.b_edge !== exp_b_edge(t))
        $display("FAIL %s_b_edge_t%0d: got %h required %h", tag, t, bus.b_edge, exp_b_edge(t));
      else pass_cnt++;
`ifndef SYSTOLIC_FEEDER_DBUF_EN
      total_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL %s_ready_t%0d: in_ready=%b required 0", tag, t, bus.in_ready);
      else pass_cnt++;
`endif
      tick();
    end
    total_cnt++;
    if (bus.done !== 1'b1 || bus.edge_valid !== 1'b0 || bus.a_edge !== '0 || bus.b_edge !== '0)
      $display("FAIL %s_done: done=%b valid=%b a=%h b=%h required 1/0/0/0", tag, bus.done, bus.edge_valid, bus.a_edge, bus.b_edge);
    else pass_cnt++;
  endtask

  task automatic ack_done(input string tag, input logic expect_clear);
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
    total_cnt++;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || bus.pe_clear !== expect_clear)
      $display("FAIL %s_ack: done=%b in_ready=%b pe_clear=%b required 0/1/%b", tag, bus.done, bus.in_ready, bus.pe_clear, expect_clear);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.done_ack = 1'b0;
    bus.in_a_col = '0;
    bus.in_b_row = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.pe_clear !== 1'b0 || bus.edge_valid !== 1'b0 ||
        bus.a_edge !== '0 || bus.b_edge !== '0 || bus.done !== 1'b0)
      $display("FAIL reset_state: ready/clear/valid/done=%b%b%b%b a=%h b=%h required 1000 0 0",
               bus.in_ready, bus.pe_clear, bus.edge_valid, bus.done, bus.a_edge, bus.b_edge);
    else pass_cnt++;
  endtask

  task automatic test_identity();
    int cyc, pulses;
    logic [W-1:0] a0, a3, a6, b6;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ld_a[r][c] = (r == c) ? DS'(1) : DS'(0);
        ld_b[r][c] = (r == c) ? DS'(1) : DS'(0);
      end
    load_tile(1'b0);
    commit_tile();
    cyc = 1;
    pulses = (bus.pe_clear === 1'b1) ? 1 : 0;
    a0 = 'x; a3 = 'x; a6 = 'x; b6 = 'x;
    while (bus.done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
      if (bus.pe_clear === 1'b1) pulses++;
      if (cyc == 2) a0 = bus.a_edge;
      if (cyc == 5) a3 = bus.a_edge;
      if (cyc == 8) begin a6 = bus.a_edge; b6 = bus.b_edge; end
    end
    total_cnt++;
    if (pulses != 1) $display("FAIL ident_clear_pulse: %0d cycles required 1", pulses);
    else pass_cnt++;
    total_cnt++;
    if (cyc != 3*N) $display("FAIL ident_done_latency: done at c+%0d required c+%0d", cyc, 3*N);
    else pass_cnt++;
    total_cnt++;
    if (a0 !== 32'h0000_0001) $display("FAIL ident_a_t0: got %h required 00000001", a0);
    else pass_cnt++;
    total_cnt++;
    if (a3 !== 32'h0000_0000) $display("FAIL ident_a_t3: got %h required 00000000", a3);
    else pass_cnt++;
    total_cnt++;
    if (a6 !== 32'h0100_0000 || b6 !== 32'h0100_0000)
      $display("FAIL ident_t6: a=%h b=%h required 01000000", a6, b6);
    else pass_cnt++;
    ack_done("ident", 1'b0);
  endtask

  task automatic test_pattern();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ld_a[r][c] = DS'(r + 1);
        ld_b[r][c] = DS'(r + c);
      end
    load_tile(1'b0);
    commit_tile();
    check_tile_stream("pattern");
    ack_done("pattern", 1'b0);
  endtask

  task automatic test_random_gaps();
    for (int n = 0; n < 3; n++) begin
      rand_tile();
      load_tile(1'b1);
      commit_tile();
      check_tile_stream($sformatf("gaps%0d", n));
      ack_done($sformatf("gaps%0d", n), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    rand_tile();
    load_tile(1'b0);
    commit_tile();
    repeat (6) tick();
    total_cnt++;
    if (bus.edge_valid !== 1'b1 || bus.a_edge !== exp_a_edge(5))
      $display("FAIL rstmid_pre: valid=%b a=%h required 1 %h", bus.edge_valid, bus.a_edge, exp_a_edge(5));
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.pe_clear !== 1'b0 || bus.edge_valid !== 1'b0 ||
        bus.a_edge !== '0 || bus.b_edge !== '0 || bus.done !== 1'b0)
      $display("FAIL rstmid_async: ready/clear/valid/done=%b%b%b%b a=%h b=%h required 1000 0 0",
               bus.in_ready, bus.pe_clear, bus.edge_valid, bus.done, bus.a_edge, bus.b_edge);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    // Two stray beats, then reset again: the beat counter must restart at 0.
    bus.in_valid = 1'b1;
    bus.in_a_col = W'($urandom);
    bus.in_b_row = W'($urandom);
    tick();
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    rand_tile();
    load_tile(1'b1);
    commit_tile();
    check_tile_stream("rstmid");
    ack_done("rstmid", 1'b0);
  endtask

  task automatic test_done_hold();
    rand_tile();
    load_tile(1'b0);
    commit_tile();
    check_tile_stream("hold");
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    bus.in_valid = 1'b0;
`else
    bus.in_valid = 1'b1;
`endif
    bus.in_a_col = W'($urandom);
    bus.in_b_row = W'($urandom);
    for (int c = 0; c < 20; c++) begin
      total_cnt++;
      if (bus.done !== 1'b1 || bus.edge_valid !== 1'b0 || bus.a_edge !== '0 || bus.b_edge !== '0)
        $display("FAIL hold_c%0d: done=%b valid=%b a=%h b=%h required 1/0/0/0", c, bus.done, bus.edge_valid, bus.a_edge, bus.b_edge);
      else pass_cnt++;
`ifndef SYSTOLIC_FEEDER_DBUF_EN
      total_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL hold_ready_c%0d: in_ready=%b required 0", c, bus.in_ready);
      else pass_cnt++;
`endif
      tick();
    end
    bus.in_valid = 1'b0;
    ack_done("hold", 1'b0);
    rand_tile();
    load_tile(1'b0);
    commit_tile();
    check_tile_stream("after_hold");
    ack_done("after_hold", 1'b0);
  endtask

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  task automatic test_dbuf();
    rand_tile();
    load_tile(1'b0);
    commit_tile();
    rand_tile();
    fork
      check_tile_stream("dbuf1");
      load_tile(1'b1);
    join
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL dbuf_both_full: in_ready=%b required 0", bus.in_ready);
    else pass_cnt++;
    commit_tile();
    ack_done("dbuf1", 1'b1);
    check_tile_stream("dbuf2");
    ack_done("dbuf2", 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_pattern();
    test_random_gaps();
    test_reset_mid();
    test_done_hold();
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    test_dbuf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
